// File: rtl/seq_game_pkg.sv
// ---------------------------------------------------------------------------
// seq_game_pkg
//   Shared definitions for the Sequence Memory Game datapath stages.
//   SYM_W       : width of one displayed symbol (hex digit).
//   seq_state_t : playback FSM encoding (IDLE=0, SHOW=1, GAP=2, FIN=3).
//   max_int     : elaboration-time helper used to size shared counters.
// ---------------------------------------------------------------------------
package seq_game_pkg;

    localparam int SYM_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2,
        FIN  = 2'd3
    } seq_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seq_playback_if.sv
// ---------------------------------------------------------------------------
// seq_playback_if
//   Bundles the write port, playback control and display outputs of
//   seq_playback.
//   Optional macro: SEQ_PAUSE_EN adds the 'pause' input.
//   Signals:
//     wr_en/wr_addr/wr_data : sequence memory write (dropped while busy)
//     start/level           : playback request and symbol count
//     pause                 : freeze playback (SEQ_PAUSE_EN only)
//     digit/blank/dp_n      : decoder feed
//     busy/done             : playback status, done is a one-cycle pulse
//     dbg_state             : current FSM state, for observation only
//   Handshake: start is level-sensitive and is only honoured in IDLE; there
//   is no ready signal, a caller waits for done (or busy low) instead.
//   Modports: slave = the playback block, master = whoever drives it.
// ---------------------------------------------------------------------------
interface seq_playback_if #(
    parameter int DEPTH = 16
);
    import seq_game_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);
    localparam int LVL_W = IDX_W + 1;

    logic              wr_en;
    logic [IDX_W-1:0]  wr_addr;
    logic [SYM_W-1:0]  wr_data;
    logic              start;
    logic [LVL_W-1:0]  level;
`ifdef SEQ_PAUSE_EN
    logic              pause;
`endif
    logic [SYM_W-1:0]  digit;
    logic              blank;
    logic              dp_n;
    logic              busy;
    logic              done;
    seq_state_t        dbg_state;

`ifdef SEQ_PAUSE_EN
    modport slave (
        input  wr_en, wr_addr, wr_data, start, level, pause,
        output digit, blank, dp_n, busy, done, dbg_state
    );
    modport master (
        output wr_en, wr_addr, wr_data, start, level, pause,
        input  digit, blank, dp_n, busy, done, dbg_state
    );
`else
    modport slave (
        input  wr_en, wr_addr, wr_data, start, level,
        output digit, blank, dp_n, busy, done, dbg_state
    );
    modport master (
        output wr_en, wr_addr, wr_data, start, level,
        input  digit, blank, dp_n, busy, done, dbg_state
    );
`endif

endinterface

// File: rtl/play_timer.sv
// ---------------------------------------------------------------------------
// play_timer
//   Loadable down-counter that saturates at zero.
//   Ports:
//     clk, reset : clock, asynchronous active-high reset (count -> 0)
//     i_load     : load i_value (takes priority over i_en)
//     i_value    : value to load
//     i_en       : decrement by one when nonzero
//     o_zero     : count is zero
// ---------------------------------------------------------------------------
module play_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    input  logic         i_en,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/seq_playback.sv
// ---------------------------------------------------------------------------
// seq_playback
//   Stores the game's symbol sequence and replays its first 'level' entries,
//   each shown for ON_CYCLES clocks and followed by OFF_CYCLES blank clocks.
//   Optional macro: SEQ_PAUSE_EN enables bus.pause, which freezes SHOW/GAP.
//   Ports:
//     clk   : system clock, rising edge
//     reset : asynchronous active-high reset
//     bus   : seq_playback_if.slave (write port, start/level, display outs)
//   All outputs are registered; the values loaded on a state transition are
//   the ones for the state being entered, so the first symbol appears the
//   cycle right after start is sampled.
// ---------------------------------------------------------------------------
module seq_playback
    import seq_game_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int ON_CYCLES  = 25000000,
    parameter int OFF_CYCLES = 12500000
) (
    input  logic          clk,
    input  logic          reset,
    seq_playback_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int LVL_W = IDX_W + 1;
    localparam int TMR_W = $clog2(max_int(ON_CYCLES, OFF_CYCLES) + 1);
    localparam logic [TMR_W-1:0] TMR_ON  = TMR_W'(ON_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_OFF = TMR_W'(OFF_CYCLES - 1);

    logic [SYM_W-1:0] r_mem [DEPTH];
    seq_state_t       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_last;     // index of the final symbol, captured at start
    logic [SYM_W-1:0] r_digit;
    logic             r_blank;
    logic             r_dp_n;
    logic             r_busy;
    logic             r_done;

    logic [LVL_W-1:0] w_lvl_c;
    logic [IDX_W-1:0] w_last_new;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [SYM_W-1:0] w_rd0;
    logic             w_wr_ok;
    logic             w_is_last;
    logic             w_run;
    logic             w_tmr_load;
    logic [TMR_W-1:0] w_tmr_val;
    logic             w_tmr_en;
    logic             w_tmr_zero;

    // Levels beyond the memory size play the whole memory.
    assign w_lvl_c    = (bus.level > LVL_W'(DEPTH)) ? LVL_W'(DEPTH) : bus.level;
    assign w_last_new = IDX_W'(w_lvl_c - LVL_W'(1));
    assign w_idx_nxt  = r_idx + IDX_W'(1);
    assign w_is_last  = (r_idx == r_last);
    assign w_wr_ok    = bus.wr_en && ((r_state == IDLE) || (r_state == FIN));

    // A write to slot 0 in the start cycle must be the symbol shown first.
    assign w_rd0 = (bus.wr_en && (bus.wr_addr == '0)) ? bus.wr_data : r_mem[0];

`ifdef SEQ_PAUSE_EN
    assign w_run = ~bus.pause;
`else
    assign w_run = 1'b1;
`endif

    always_comb begin
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        w_tmr_en   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start && (w_lvl_c != '0)) begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = TMR_ON;
                end
            end
            SHOW: begin
                if (w_run) begin
                    if (w_tmr_zero) begin
                        w_tmr_load = 1'b1;
                        w_tmr_val  = TMR_OFF;
                    end else begin
                        w_tmr_en = 1'b1;
                    end
                end
            end
            GAP: begin
                if (w_run) begin
                    if (w_tmr_zero) begin
                        if (!w_is_last) begin
                            w_tmr_load = 1'b1;
                            w_tmr_val  = TMR_ON;
                        end
                    end else begin
                        w_tmr_en = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    play_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_tmr_load),
        .i_value (w_tmr_val),
        .i_en    (w_tmr_en),
        .o_zero  (w_tmr_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_state <= IDLE;
            r_idx   <= '0;
            r_last  <= '0;
            r_digit <= '0;
            r_blank <= 1'b1;
            r_dp_n  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (w_wr_ok) begin
                r_mem[bus.wr_addr] <= bus.wr_data;
            end

            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        if (w_lvl_c != '0) begin
                            r_state <= SHOW;
                            r_idx   <= '0;
                            r_last  <= w_last_new;
                            r_digit <= w_rd0;
                            r_blank <= 1'b0;
                            r_dp_n  <= (w_last_new != '0);
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= FIN;
                            r_done  <= 1'b1;
                        end
                    end
                end
                SHOW: begin
                    if (w_run && w_tmr_zero) begin
                        r_state <= GAP;
                        r_digit <= '0;
                        r_blank <= 1'b1;
                        r_dp_n  <= 1'b1;
                    end
                end
                GAP: begin
                    if (w_run && w_tmr_zero) begin
                        if (w_is_last) begin
                            r_state <= FIN;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= SHOW;
                            r_idx   <= w_idx_nxt;
                            r_digit <= r_mem[w_idx_nxt];
                            r_blank <= 1'b0;
                            r_dp_n  <= (w_idx_nxt != r_last);
                        end
                    end
                end
                FIN: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.digit     = r_digit;
    assign bus.blank     = r_blank;
    assign bus.dp_n      = r_dp_n;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_seq_playback.sv
// ---------------------------------------------------------------------------
// tb_seq_playback
//   Directed bench for seq_playback with DEPTH=4, ON_CYCLES=3, OFF_CYCLES=2.
//   Cycle 0 is the cycle in which start is held high; outputs are sampled
//   on the falling edge of each cycle.
// ---------------------------------------------------------------------------
module tb_seq_playback;
    import seq_game_pkg::*;

    localparam int DEPTH = 4;
    localparam int ON_C  = 3;
    localparam int OFF_C = 2;
    localparam int PER   = ON_C + OFF_C;

    typedef struct {
        int         scen;
        int         cyc;
        logic [3:0] digit;
        logic       blank;
        logic       dp_n;
        logic       busy;
        logic       done;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    logic [3:0] exp_mem [DEPTH];
    vec_t tbl [$];

    seq_playback_if #(.DEPTH(DEPTH)) bus ();

    seq_playback #(
        .DEPTH      (DEPTH),
        .ON_CYCLES  (ON_C),
        .OFF_CYCLES (OFF_C)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic vec_t mk(input int s, input int c, input logic [3:0] d,
                                input logic b, input logic dp, input logic bu,
                                input logic dn);
        vec_t v;
        v.scen = s; v.cyc = c; v.digit = d; v.blank = b;
        v.dp_n = dp; v.busy = bu; v.done = dn;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected outputs for cycle c of a playback started in cycle 0.
    task automatic model(input int lvl, input int c, output logic [3:0] d,
                         output logic b, output logic dp, output logic bu,
                         output logic dn);
        int L, k, off;
        L  = (lvl > DEPTH) ? DEPTH : lvl;
        d  = 4'h0; b = 1'b1; dp = 1'b1; bu = 1'b0; dn = 1'b0;
        if (c >= 1 && c <= L * PER) begin
            k   = (c - 1) / PER;
            off = (c - 1) % PER;
            bu  = 1'b1;
            if (off < ON_C) begin
                d  = exp_mem[k];
                b  = 1'b0;
                dp = (k != L - 1);
            end
        end
        if (c == 1 + L * PER) dn = 1'b1;
    endtask

    task automatic check_cycle(input int scen, input int lvl, input int c);
        logic [3:0] d;
        logic b, dp, bu, dn;
        model(lvl, c, d, b, dp, bu, dn);
        chk($sformatf("s%0d_c%0d_digit", scen, c), 32'(bus.digit), 32'(d));
        chk($sformatf("s%0d_c%0d_blank", scen, c), 32'(bus.blank), 32'(b));
        chk($sformatf("s%0d_c%0d_dp_n",  scen, c), 32'(bus.dp_n),  32'(dp));
        chk($sformatf("s%0d_c%0d_busy",  scen, c), 32'(bus.busy),  32'(bu));
        chk($sformatf("s%0d_c%0d_done",  scen, c), 32'(bus.done),  32'(dn));
        foreach (tbl[i]) begin
            if (scen != 0 && tbl[i].scen == scen && tbl[i].cyc == c) begin
                chk($sformatf("tbl%0d_c%0d_digit", scen, c), 32'(bus.digit), 32'(tbl[i].digit));
                chk($sformatf("tbl%0d_c%0d_blank", scen, c), 32'(bus.blank), 32'(tbl[i].blank));
                chk($sformatf("tbl%0d_c%0d_dp_n",  scen, c), 32'(bus.dp_n),  32'(tbl[i].dp_n));
                chk($sformatf("tbl%0d_c%0d_busy",  scen, c), 32'(bus.busy),  32'(tbl[i].busy));
                chk($sformatf("tbl%0d_c%0d_done",  scen, c), 32'(bus.done),  32'(tbl[i].done));
            end
        end
    endtask

    task automatic write_mem(input int addr, input logic [3:0] data);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr[1:0];
        bus.wr_data = data;
        exp_mem[addr] = data;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic play(input int scen, input int lvl, input int ncyc);
        @(negedge clk);
        bus.start = 1'b1;
        bus.level = lvl[2:0];
        check_cycle(scen, lvl, 0);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            check_cycle(scen, lvl, c);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = 4'h0;

        // Hand-computed vectors for mem = {7,2,C,5}.
        // scen 1: level=3, scen 2: level=1, scen 3: level=0, scen 4: level=7.
        tbl.push_back(mk(1,  0, 4'h0, 1, 1, 0, 0));
        tbl.push_back(mk(1,  1, 4'h7, 0, 1, 1, 0));
        tbl.push_back(mk(1,  3, 4'h7, 0, 1, 1, 0));
        tbl.push_back(mk(1,  4, 4'h0, 1, 1, 1, 0));
        tbl.push_back(mk(1,  5, 4'h0, 1, 1, 1, 0));
        tbl.push_back(mk(1,  6, 4'h2, 0, 1, 1, 0));
        tbl.push_back(mk(1,  8, 4'h2, 0, 1, 1, 0));
        tbl.push_back(mk(1, 10, 4'h0, 1, 1, 1, 0));
        tbl.push_back(mk(1, 11, 4'hC, 0, 0, 1, 0));
        tbl.push_back(mk(1, 13, 4'hC, 0, 0, 1, 0));
        tbl.push_back(mk(1, 14, 4'h0, 1, 1, 1, 0));
        tbl.push_back(mk(1, 15, 4'h0, 1, 1, 1, 0));
        tbl.push_back(mk(1, 16, 4'h0, 1, 1, 0, 1));
        tbl.push_back(mk(1, 17, 4'h0, 1, 1, 0, 0));
        tbl.push_back(mk(2,  1, 4'h7, 0, 0, 1, 0));
        tbl.push_back(mk(2,  3, 4'h7, 0, 0, 1, 0));
        tbl.push_back(mk(2,  5, 4'h0, 1, 1, 1, 0));
        tbl.push_back(mk(2,  6, 4'h0, 1, 1, 0, 1));
        tbl.push_back(mk(3,  1, 4'h0, 1, 1, 0, 1));
        tbl.push_back(mk(3,  2, 4'h0, 1, 1, 0, 0));
        tbl.push_back(mk(4, 11, 4'hC, 0, 1, 1, 0));
        tbl.push_back(mk(4, 16, 4'h5, 0, 0, 1, 0));
        tbl.push_back(mk(4, 18, 4'h5, 0, 0, 1, 0));
        tbl.push_back(mk(4, 20, 4'h0, 1, 1, 1, 0));
        tbl.push_back(mk(4, 21, 4'h0, 1, 1, 0, 1));
        tbl.push_back(mk(4, 22, 4'h0, 1, 1, 0, 0));

        reset       = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.start   = 1'b0;
        bus.level   = '0;
`ifdef SEQ_PAUSE_EN
        bus.pause   = 1'b0;
`endif
        repeat (2) @(negedge clk);

        // Reset values.
        chk("rst_digit", 32'(bus.digit), 32'h0);
        chk("rst_blank", 32'(bus.blank), 32'h1);
        chk("rst_dp_n",  32'(bus.dp_n),  32'h1);
        chk("rst_busy",  32'(bus.busy),  32'h0);
        chk("rst_done",  32'(bus.done),  32'h0);
        chk("rst_state", 32'(bus.dbg_state), 32'(IDLE));
        reset = 1'b0;

        write_mem(0, 4'h7);
        write_mem(1, 4'h2);
        write_mem(2, 4'hC);
        write_mem(3, 4'h5);

        // Reset in the middle of SHOW takes effect without a clock edge.
        @(negedge clk);
        bus.start = 1'b1;
        bus.level = 3'd3;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        chk("pre_rst_digit", 32'(bus.digit), 32'h7);
        #2 reset = 1'b1;
        #1;
        chk("midrst_blank", 32'(bus.blank), 32'h1);
        chk("midrst_busy",  32'(bus.busy),  32'h0);
        chk("midrst_digit", 32'(bus.digit), 32'h0);
        chk("midrst_dp_n",  32'(bus.dp_n),  32'h1);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = 4'h0;
        play(0, 3, 17);   // memory cleared: zeros shown

        write_mem(0, 4'h7);
        write_mem(1, 4'h2);
        write_mem(2, 4'hC);
        write_mem(3, 4'h5);

        play(1, 3, 17);
        play(2, 1, 7);
        play(3, 0, 3);
        play(4, 7, 22);

        // Write during GAP is dropped; level change mid-play is ignored.
        @(negedge clk);
        bus.start = 1'b1;
        bus.level = 3'd1;
        check_cycle(0, 1, 0);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            if (c == 2) bus.level = 3'd4;
            if (c == 4) begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = 2'd0;
                bus.wr_data = 4'h9;
            end
            if (c == 5) bus.wr_en = 1'b0;
            check_cycle(0, 1, c);
        end
        play(0, 1, 7);

        // Write and start in the same IDLE cycle: new value is shown.
        @(negedge clk);
        bus.start   = 1'b1;
        bus.level   = 3'd1;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 2'd0;
        bus.wr_data = 4'hA;
        exp_mem[0]  = 4'hA;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.start = 1'b0;
                bus.wr_en = 1'b0;
                chk("wr_start_digit", 32'(bus.digit), 32'hA);
            end
            check_cycle(0, 1, c);
        end
        write_mem(0, 4'h7);

        // start held high: FIN, one IDLE cycle, then the replay.
        @(negedge clk);
        bus.start = 1'b1;
        bus.level = 3'd1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 13) bus.start = 1'b0;
            check_cycle(0, 1, (c >= 7) ? c - 7 : c);
        end

`ifdef SEQ_PAUSE_EN
        // Pause during symbol 0 (cycles 2..5) stretches it to 7 cycles.
        @(negedge clk);
        bus.start = 1'b1;
        bus.level = 3'd3;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            if (c == 1) bus.start = 1'b0;
            if (c == 2) bus.pause = 1'b1;
            if (c == 6) bus.pause = 1'b0;
            if (c == 7)  chk("pause_sym0_end", 32'(bus.digit), 32'h7);
            if (c == 8)  chk("pause_gap_blank", 32'(bus.blank), 32'h1);
            if (c == 20) chk("pause_done", 32'(bus.done), 32'h1);
            check_cycle(0, 3, (c < 2) ? c : ((c <= 5) ? 1 : c - 4));
        end
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
